// File: rtl/dl11_pkg.sv
// Shared definitions for the DL11 serial line unit: register indices, bit positions,
// shifter state encoding and the bus-side register file layout.
package dl11_pkg;

    // Register index = bus_addr[2:1]
    localparam logic [1:0] REG_RCSR = 2'd0;
    localparam logic [1:0] REG_RBUF = 2'd1;
    localparam logic [1:0] REG_XCSR = 2'd2;
    localparam logic [1:0] REG_XBUF = 2'd3;

    // Bit positions inside the CSR/BUF words
    localparam int unsigned BIT_DONE  = 7;
    localparam int unsigned BIT_READY = 7;
    localparam int unsigned BIT_IE    = 6;
    localparam int unsigned BIT_MAINT = 2;
    localparam int unsigned BIT_ERR   = 15;
    localparam int unsigned BIT_OVR   = 14;
    localparam int unsigned BIT_FRM   = 13;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } shift_state_e;

    // Bus-side state of the unit; everything here resets together.
    typedef struct packed {
        logic       stb;       // previous sel & bus_stb, for edge detection
        logic       ack;
        logic       rx_done;
        logic       rx_ie;
        logic       tx_ie;
        logic       maint;
        logic       tx_ready;
        logic       rx_ovr;
        logic       rx_frm;
        logic [7:0] rx_data;
        logic [7:0] tx_buf;
        logic       rx_cond;   // previous rx_ie & rx_done
        logic       tx_cond;   // previous tx_ie & tx_ready
        logic       rx_pend;
        logic       tx_pend;
    } dl11_regs_t;

    localparam dl11_regs_t REGS_RESET = '{
        stb: 1'b0, ack: 1'b0, rx_done: 1'b0, rx_ie: 1'b0, tx_ie: 1'b0, maint: 1'b0,
        tx_ready: 1'b1, rx_ovr: 1'b0, rx_frm: 1'b0, rx_data: 8'h00, tx_buf: 8'h00,
        rx_cond: 1'b0, tx_cond: 1'b0, rx_pend: 1'b0, tx_pend: 1'b0
    };

endpackage

// File: rtl/dl11_rx_shifter.sv
// 8N1 receiver for the DL11 unit.
// Ports: clk_sys/reset_n/init clock and resets; rxd raw serial input; loop_en/loop_line select
// the internal transmitter line instead of rxd; data/frm hold the last frame (frm = bad stop
// bit); valid pulses for one cycle when a frame is latched.
module dl11_rx_shifter
    import dl11_pkg::*;
#(
    parameter int unsigned DIV = 217
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       init,
    input  logic       rxd,
    input  logic       loop_en,
    input  logic       loop_line,
    output logic [7:0] data,
    output logic       frm,
    output logic       valid
);

    localparam int unsigned CW = $clog2(DIV);

    logic [1:0]    sync_q;
    logic          prev_q;
    logic          line;
    shift_state_e  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sr_q, sr_d;
    logic [7:0]    data_q, data_d;
    logic          frm_q, frm_d;
    logic          valid_q, valid_d;
    logic          tick;

    assign line = loop_en ? loop_line : sync_q[1];

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            sr_q    <= '0;
            data_q  <= '0;
            frm_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            sync_q  <= init ? 2'b11 : {sync_q[0], rxd};
            prev_q  <= init ? 1'b1 : line;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sr_q    <= sr_d;
            data_q  <= data_d;
            frm_q   <= frm_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sr_d    = sr_q;
        data_d  = data_q;
        frm_d   = frm_q;
        valid_d = 1'b0;
        tick    = (cnt_q == '0);
        if (state_q != StIdle && !tick) cnt_d = cnt_q - 1'b1;
        unique case (state_q)
            StIdle: begin
                // Falling edge only: a low line left over from a framing error must not retrigger
                if (prev_q && !line) begin
                    state_d = StStart;
                    cnt_d   = CW'(DIV / 2 - 1);
                end
            end
            StStart: begin
                if (tick) begin
                    if (line) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StData;
                        cnt_d   = CW'(DIV - 1);
                        bit_d   = '0;
                    end
                end
            end
            StData: begin
                if (tick) begin
                    sr_d  = {line, sr_q[7:1]};
                    bit_d = bit_q + 1'b1;
                    cnt_d = CW'(DIV - 1);
                    if (bit_q == 3'd7) state_d = StStop;
                end
            end
            StStop: begin
                if (tick) begin
                    valid_d = 1'b1;
                    data_d  = sr_q;
                    frm_d   = !line;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (init) begin
            state_d = StIdle;
            cnt_d   = '0;
            bit_d   = '0;
            sr_d    = '0;
            data_d  = '0;
            frm_d   = 1'b0;
            valid_d = 1'b0;
        end
    end

    assign data  = data_q;
    assign frm   = frm_q;
    assign valid = valid_q;

endmodule

// File: rtl/serial_port_dl11.sv
// DL11-style serial line unit on the VM1 MPI bus: RCSR/RBUF/XCSR/XBUF at BASE..BASE+6,
// 8N1 transmitter on txd, receiver on rxd (or internal loopback in maintenance mode),
// RX/TX interrupt requests with vic acknowledge.
// Ports: clk_sys, reset_n (async), init (sync); ce bus clock enable; bus_* responder side
// (bus_dout is zero when not selected); rxd/txd serial lines; rx_req/rx_ack, tx_req/tx_ack.
module serial_port_dl11
    import dl11_pkg::*;
#(
    parameter logic [15:0] BASE = 16'o176560,
    parameter int unsigned DIV  = 217
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ce,
    input  logic        init,
    input  logic [15:0] bus_addr,
    input  logic        bus_sync,
    input  logic        bus_we,
    input  logic [1:0]  bus_wtbt,
    input  logic        bus_stb,
    input  logic [15:0] bus_din,
    output logic [15:0] bus_dout,
    output logic        bus_ack,
    input  logic        rxd,
    output logic        txd,
    output logic        rx_req,
    input  logic        rx_ack,
    output logic        tx_req,
    input  logic        tx_ack
);

    localparam int unsigned CW = $clog2(DIV);

    dl11_regs_t    regs_q, regs_d;
    shift_state_e  tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_sr_q, tx_sr_d;
    logic          tx_line, tx_tick, tx_enter_stop;
    logic          sel, edge_hit, wr_lo;
    logic [1:0]    idx;
    logic [15:0]   rd_val;
    logic [7:0]    rx_data;
    logic          rx_frm, rx_valid;
    logic          rx_cond, tx_cond;
    logic          unused_bits;

    assign unused_bits = ^{bus_addr[0], bus_din[15:8], bus_din[7], bus_din[5:3],
                           bus_din[1:0], bus_wtbt[1]};

    assign sel      = bus_sync && (bus_addr[15:3] == BASE[15:3]);
    assign idx      = bus_addr[2:1];
    // Side effects fire once per bus cycle, on the rising edge of sel & bus_stb
    assign edge_hit = sel && bus_stb && !regs_q.stb;
    assign wr_lo    = edge_hit && bus_we && bus_wtbt[0];

    dl11_rx_shifter #(
        .DIV (DIV)
    ) u_rx (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .init      (init),
        .rxd       (rxd),
        .loop_en   (regs_q.maint),
        .loop_line (tx_line),
        .data      (rx_data),
        .frm       (rx_frm),
        .valid     (rx_valid)
    );

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            regs_q     <= REGS_RESET;
            tx_state_q <= StIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_sr_q    <= '0;
        end else begin
            regs_q     <= init ? REGS_RESET : regs_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_sr_q    <= tx_sr_d;
        end
    end

    // Transmitter; a cleared TX_READY in Idle/Stop means a byte is waiting in tx_buf
    always_comb begin
        tx_state_d    = tx_state_q;
        tx_cnt_d      = tx_cnt_q;
        tx_bit_d      = tx_bit_q;
        tx_sr_d       = tx_sr_q;
        tx_enter_stop = 1'b0;
        tx_line       = 1'b1;
        tx_tick       = (tx_cnt_q == '0);
        if (tx_state_q != StIdle && !tx_tick) tx_cnt_d = tx_cnt_q - 1'b1;
        unique case (tx_state_q)
            StIdle: begin
                if (!regs_q.tx_ready) begin
                    tx_state_d = StStart;
                    tx_cnt_d   = CW'(DIV - 1);
                    tx_sr_d    = regs_q.tx_buf;
                end
            end
            StStart: begin
                tx_line = 1'b0;
                if (tx_tick) begin
                    tx_state_d = StData;
                    tx_cnt_d   = CW'(DIV - 1);
                    tx_bit_d   = '0;
                end
            end
            StData: begin
                tx_line = tx_sr_q[0];
                if (tx_tick) begin
                    tx_sr_d  = {1'b0, tx_sr_q[7:1]};
                    tx_bit_d = tx_bit_q + 1'b1;
                    tx_cnt_d = CW'(DIV - 1);
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d    = StStop;
                        tx_enter_stop = 1'b1;
                    end
                end
            end
            StStop: begin
                if (tx_tick) begin
                    if (!regs_q.tx_ready) begin
                        tx_state_d = StStart;
                        tx_cnt_d   = CW'(DIV - 1);
                        tx_sr_d    = regs_q.tx_buf;
                    end else begin
                        tx_state_d = StIdle;
                    end
                end
            end
            default: tx_state_d = StIdle;
        endcase
        if (init) begin
            tx_state_d    = StIdle;
            tx_cnt_d      = '0;
            tx_bit_d      = '0;
            tx_sr_d       = '0;
            tx_enter_stop = 1'b0;
        end
    end

    assign rx_cond = regs_q.rx_ie && regs_q.rx_done;
    assign tx_cond = regs_q.tx_ie && regs_q.tx_ready;

    // Bus register file and interrupt pending flags
    always_comb begin
        regs_d     = regs_q;
        regs_d.stb = sel && bus_stb;
        if (ce) regs_d.ack = bus_stb && (regs_q.ack || sel);

        if (wr_lo) begin
            unique case (idx)
                REG_RCSR: regs_d.rx_ie = bus_din[BIT_IE];
                REG_XCSR: begin
                    regs_d.tx_ie = bus_din[BIT_IE];
                    regs_d.maint = bus_din[BIT_MAINT];
                end
                REG_XBUF: begin
                    if (regs_q.tx_ready) begin
                        regs_d.tx_buf   = bus_din[7:0];
                        regs_d.tx_ready = 1'b0;
                    end
                end
                default: ;
            endcase
        end
        if (tx_enter_stop) regs_d.tx_ready = 1'b1;

        // A frame latch on the same edge as an RBUF read wins
        if (rx_valid) begin
            regs_d.rx_data = rx_data;
            regs_d.rx_frm  = rx_frm;
            regs_d.rx_ovr  = regs_q.rx_done;
            regs_d.rx_done = 1'b1;
        end else if (edge_hit && !bus_we && idx == REG_RBUF) begin
            regs_d.rx_done = 1'b0;
        end

        regs_d.rx_cond = rx_cond;
        regs_d.tx_cond = tx_cond;
        if (!rx_cond)                regs_d.rx_pend = 1'b0;
        else if (!regs_q.rx_cond)    regs_d.rx_pend = 1'b1;
        else if (rx_ack)             regs_d.rx_pend = 1'b0;
        if (!tx_cond)                regs_d.tx_pend = 1'b0;
        else if (!regs_q.tx_cond)    regs_d.tx_pend = 1'b1;
        else if (tx_ack)             regs_d.tx_pend = 1'b0;
    end

    always_comb begin
        rd_val = '0;
        unique case (idx)
            REG_RCSR: begin
                rd_val[BIT_ERR]  = regs_q.rx_ovr || regs_q.rx_frm;
                rd_val[BIT_DONE] = regs_q.rx_done;
                rd_val[BIT_IE]   = regs_q.rx_ie;
            end
            REG_RBUF: begin
                rd_val[7:0]     = regs_q.rx_data;
                rd_val[BIT_ERR] = regs_q.rx_ovr || regs_q.rx_frm;
                rd_val[BIT_OVR] = regs_q.rx_ovr;
                rd_val[BIT_FRM] = regs_q.rx_frm;
            end
            REG_XCSR: begin
                rd_val[BIT_READY] = regs_q.tx_ready;
                rd_val[BIT_IE]    = regs_q.tx_ie;
                rd_val[BIT_MAINT] = regs_q.maint;
            end
            default: rd_val = '0;
        endcase
    end

    assign bus_dout = (sel && bus_stb && !bus_we) ? rd_val : 16'h0000;
    assign bus_ack  = regs_q.ack;
    assign txd      = regs_q.maint || tx_line;
    assign rx_req   = regs_q.rx_pend;
    assign tx_req   = regs_q.tx_pend;

endmodule

// File: tb/tb_serial_port_dl11.sv
// Directed self-checking bench for serial_port_dl11 with DIV=16.
module tb_serial_port_dl11;

    localparam int unsigned DIV = 16;
    localparam logic [15:0] A_RCSR = 16'o176560;
    localparam logic [15:0] A_RBUF = 16'o176562;
    localparam logic [15:0] A_XCSR = 16'o176564;
    localparam logic [15:0] A_XBUF = 16'o176566;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ce = 1'b1;
    logic        init = 1'b0;
    logic [15:0] bus_addr = '0;
    logic        bus_sync = 1'b0;
    logic        bus_we = 1'b0;
    logic [1:0]  bus_wtbt = 2'b00;
    logic        bus_stb = 1'b0;
    logic [15:0] bus_din = '0;
    logic [15:0] bus_dout;
    logic        bus_ack;
    logic        rxd = 1'b1;
    logic        txd;
    logic        rx_req, tx_req;
    logic        rx_ack = 1'b0;
    logic        tx_ack = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    logic txlog [0:4095];

    serial_port_dl11 #(
        .BASE (16'o176560),
        .DIV  (DIV)
    ) dut (
        .clk_sys  (clk),
        .reset_n  (reset_n),
        .ce       (ce),
        .init     (init),
        .bus_addr (bus_addr),
        .bus_sync (bus_sync),
        .bus_we   (bus_we),
        .bus_wtbt (bus_wtbt),
        .bus_stb  (bus_stb),
        .bus_din  (bus_din),
        .bus_dout (bus_dout),
        .bus_ack  (bus_ack),
        .rxd      (rxd),
        .txd      (txd),
        .rx_req   (rx_req),
        .rx_ack   (rx_ack),
        .tx_req   (tx_req),
        .tx_ack   (tx_ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (cyc < 4096) txlog[cyc] = txd;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic bus_cycle(input logic [15:0] a, input logic we, input logic [15:0] d,
                             input logic [1:0] bt, output logic [15:0] q,
                             output logic acked, output logic dropped);
        @(negedge clk);
        bus_addr = a; bus_we = we; bus_din = d; bus_wtbt = bt; bus_sync = 1'b1;
        @(negedge clk);
        bus_stb = 1'b1;
        acked = 1'b0;
        for (int i = 0; i < 8 && !acked; i++) begin
            @(negedge clk);
            if (bus_ack) acked = 1'b1;
        end
        q = bus_dout;
        bus_stb = 1'b0;
        dropped = 1'b0;
        for (int i = 0; i < 8 && !dropped; i++) begin
            @(negedge clk);
            if (!bus_ack) dropped = 1'b1;
        end
        bus_sync = 1'b0; bus_we = 1'b0; bus_wtbt = 2'b00;
    endtask

    task automatic rd(input logic [15:0] a, output logic [15:0] q);
        logic ak, dr;
        bus_cycle(a, 1'b0, 16'h0000, 2'b00, q, ak, dr);
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d, input logic [1:0] bt);
        logic [15:0] q;
        logic ak, dr;
        bus_cycle(a, 1'b1, d, bt, q, ak, dr);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        @(negedge clk);
        rxd = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (DIV) @(negedge clk);
        end
        rxd = stop;
        repeat (DIV) @(negedge clk);
        rxd = 1'b1;
        repeat (DIV) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [15:0] q;
        logic ak, dr;
        #1;
        tests_run++;
        if ({txd, bus_ack, rx_req, tx_req, bus_dout} !== {4'b1000, 16'h0000}) begin
            tests_failed++;
            $display("FAIL reset_outputs: txd/ack/rxreq/txreq/dout=%b%b%b%b %h want 1000 0000",
                     txd, bus_ack, rx_req, tx_req, bus_dout);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        bus_cycle(A_XCSR, 1'b0, 16'h0, 2'b00, q, ak, dr);
        tests_run++;
        if ({q, ak, dr} !== {16'o000200, 2'b11}) begin
            tests_failed++;
            $display("FAIL xcsr_reset: got %o ack=%b drop=%b want 000200 1 1", q, ak, dr);
        end
        bus_cycle(A_RCSR, 1'b0, 16'h0, 2'b00, q, ak, dr);
        tests_run++;
        if ({q, ak, dr} !== {16'o000000, 2'b11}) begin
            tests_failed++;
            $display("FAIL rcsr_reset: got %o ack=%b drop=%b want 000000 1 1", q, ak, dr);
        end
        bus_cycle(16'o176570, 1'b0, 16'h0, 2'b00, q, ak, dr);
        tests_run++;
        if ({q, ak} !== {16'h0000, 1'b0}) begin
            tests_failed++;
            $display("FAIL unselected: got %o ack=%b want 0 0", q, ak);
        end
        tests_run++;
        if (txd !== 1'b1) begin
            tests_failed++;
            $display("FAIL txd_idle: got %b want 1", txd);
        end
    endtask

    task automatic test_tx();
        logic [15:0] q;
        logic [9:0]  bits;
        int s;
        logic found;
        bits = {1'b1, 8'o125, 1'b0};  // stop, data MSB..LSB, start
        wr(A_XBUF, 16'h5500, 2'b10);
        rd(A_XCSR, q);
        tests_run++;
        if (q !== 16'o000200) begin
            tests_failed++;
            $display("FAIL xbuf_high_only: XCSR got %o want 000200", q);
        end
        wr(A_XBUF, 16'o000125, 2'b01);
        found = 1'b0;
        s = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (txd === 1'b0) begin found = 1'b1; s = cyc; end
            else @(negedge clk);
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("FAIL tx_start: txd never went low got 1 want 0");
        end else begin
            rd(A_XCSR, q);
            tests_run++;
            if (q !== 16'o000000) begin
                tests_failed++;
                $display("FAIL tx_busy_ready: XCSR got %o want 000000", q);
            end
            while (cyc < s + 9 * DIV + 4) @(negedge clk);
            rd(A_XCSR, q);
            tests_run++;
            if (q !== 16'o000200) begin
                tests_failed++;
                $display("FAIL tx_stop_ready: XCSR got %o want 000200", q);
            end
            while (cyc < s + 11 * DIV) @(negedge clk);
            for (int i = 0; i < 10; i++) begin
                tests_run++;
                if (txlog[s + DIV * i] !== bits[i] || txlog[s + DIV * i + DIV - 1] !== bits[i]) begin
                    tests_failed++;
                    $display("FAIL tx_bit%0d: got %b/%b want %b", i, txlog[s + DIV * i],
                             txlog[s + DIV * i + DIV - 1], bits[i]);
                end
            end
            tests_run++;
            if (txlog[s + 10 * DIV + 2] !== 1'b1) begin
                tests_failed++;
                $display("FAIL tx_idle_after: got %b want 1", txlog[s + 10 * DIV + 2]);
            end
        end
    endtask

    task automatic test_rx();
        logic [15:0] q;
        send_frame(8'hA5, 1'b1);
        rd(A_RCSR, q);
        tests_run++;
        if (q !== 16'o000200) begin
            tests_failed++;
            $display("FAIL rx_rcsr_done: got %o want 000200", q);
        end
        rd(A_RBUF, q);
        tests_run++;
        if (q !== 16'o000245) begin
            tests_failed++;
            $display("FAIL rx_rbuf: got %o want 000245", q);
        end
        rd(A_RCSR, q);
        tests_run++;
        if (q !== 16'o000000) begin
            tests_failed++;
            $display("FAIL rx_rcsr_cleared: got %o want 000000", q);
        end
    endtask

    task automatic test_errors();
        logic [15:0] q;
        send_frame(8'h12, 1'b1);
        send_frame(8'h34, 1'b1);
        rd(A_RCSR, q);
        tests_run++;
        if (q !== 16'h8080) begin
            tests_failed++;
            $display("FAIL ovr_rcsr: got %h want 8080", q);
        end
        rd(A_RBUF, q);
        tests_run++;
        if (q !== 16'hC034) begin
            tests_failed++;
            $display("FAIL ovr_rbuf: got %h want c034", q);
        end
        send_frame(8'h5A, 1'b0);
        rd(A_RBUF, q);
        tests_run++;
        if (q !== 16'hA05A) begin
            tests_failed++;
            $display("FAIL frm_rbuf: got %h want a05a", q);
        end
        rd(A_RCSR, q);
        tests_run++;
        if (q !== 16'h8000) begin
            tests_failed++;
            $display("FAIL frm_rcsr: got %h want 8000", q);
        end
    endtask

    task automatic test_irq();
        logic [15:0] q;
        send_frame(8'h11, 1'b1);
        tests_run++;
        if (rx_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL rxreq_no_ie: got %b want 0", rx_req);
        end
        wr(A_RCSR, 16'o000100, 2'b01);
        repeat (2) @(negedge clk);
        tests_run++;
        if (rx_req !== 1'b1) begin
            tests_failed++;
            $display("FAIL rxreq_ie_set: got %b want 1", rx_req);
        end
        rd(A_RCSR, q);
        tests_run++;
        if (q !== 16'o000300) begin
            tests_failed++;
            $display("FAIL rcsr_ie: got %o want 000300", q);
        end
        rx_ack = 1'b1; @(negedge clk); rx_ack = 1'b0;
        repeat (10) @(negedge clk);
        tests_run++;
        if (rx_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL rxreq_acked: got %b want 0", rx_req);
        end
        rd(A_RBUF, q);
        tests_run++;
        if (q !== 16'h0011) begin
            tests_failed++;
            $display("FAIL irq_rbuf: got %h want 0011", q);
        end
        send_frame(8'h22, 1'b1);
        tests_run++;
        if (rx_req !== 1'b1) begin
            tests_failed++;
            $display("FAIL rxreq_rearm: got %b want 1", rx_req);
        end
        rx_ack = 1'b1; @(negedge clk); rx_ack = 1'b0;
        @(negedge clk);
        wr(A_RCSR, 16'o000000, 2'b01);
        rd(A_RBUF, q);
        wr(A_XCSR, 16'o000100, 2'b01);
        repeat (2) @(negedge clk);
        tests_run++;
        if (tx_req !== 1'b1) begin
            tests_failed++;
            $display("FAIL txreq_ie_set: got %b want 1", tx_req);
        end
        tx_ack = 1'b1; @(negedge clk); tx_ack = 1'b0;
        @(negedge clk);
        tests_run++;
        if (tx_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL txreq_acked: got %b want 0", tx_req);
        end
        wr(A_XCSR, 16'o000000, 2'b01);
        // init acts like reset on the registers
        wr(A_RCSR, 16'o000100, 2'b01);
        @(negedge clk); init = 1'b1; @(negedge clk); init = 1'b0;
        rd(A_RCSR, q);
        tests_run++;
        if (q !== 16'o000000) begin
            tests_failed++;
            $display("FAIL init_rcsr: got %o want 000000", q);
        end
    endtask

    task automatic test_maint();
        logic [15:0] q;
        int zeros;
        wr(A_XCSR, 16'o000004, 2'b01);
        rd(A_XCSR, q);
        tests_run++;
        if (q !== 16'o000204) begin
            tests_failed++;
            $display("FAIL maint_xcsr: got %o want 000204", q);
        end
        wr(A_XBUF, 16'h003C, 2'b01);
        zeros = 0;
        for (int i = 0; i < 12 * DIV; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) zeros++;
        end
        tests_run++;
        if (zeros !== 0) begin
            tests_failed++;
            $display("FAIL maint_txd_high: got %0d low cycles want 0", zeros);
        end
        rd(A_RCSR, q);
        tests_run++;
        if (q !== 16'o000200) begin
            tests_failed++;
            $display("FAIL maint_rcsr: got %o want 000200", q);
        end
        rd(A_RBUF, q);
        tests_run++;
        if (q !== 16'o000074) begin
            tests_failed++;
            $display("FAIL maint_rbuf: got %o want 000074", q);
        end
        wr(A_XBUF, 16'h00FF, 2'b01);
        repeat (3 * DIV) @(negedge clk);
        reset_n = 1'b0;
        #1;
        tests_run++;
        if ({txd, bus_ack, rx_req, tx_req, bus_dout} !== {4'b1000, 16'h0000}) begin
            tests_failed++;
            $display("FAIL midframe_reset: txd/ack/rxreq/txreq/dout=%b%b%b%b %h want 1000 0000",
                     txd, bus_ack, rx_req, tx_req, bus_dout);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        zeros = 0;
        for (int i = 0; i < 12 * DIV; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) zeros++;
        end
        tests_run++;
        if (zeros !== 0) begin
            tests_failed++;
            $display("FAIL abort_txd: got %0d low cycles want 0", zeros);
        end
        rd(A_XCSR, q);
        tests_run++;
        if (q !== 16'o000200) begin
            tests_failed++;
            $display("FAIL abort_xcsr: got %o want 000200", q);
        end
        rd(A_RCSR, q);
        tests_run++;
        if (q !== 16'o000000) begin
            tests_failed++;
            $display("FAIL abort_rcsr: got %o want 000000", q);
        end
    endtask

    initial begin
        test_reset();
        test_tx();
        test_rx();
        test_errors();
        test_irq();
        test_maint();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/serial_port_dl11.md
Name: serial_port_dl11

Overview:
- DL11-style serial line unit that acts as a bus responder (target) for the VM1 CPU's MPI bus.
- Decodes four word registers at BASE, BASE+2, BASE+4 and BASE+6: RCSR, RBUF, XCSR and XBUF.
- Runs an 8N1 UART transmitter/receiver on txd/rxd.
- Raises RX/TX vectored interrupt requests toward the vic_wb controller.
- bus_dout is OR-combined into cpu_din; bus_ack is OR-combined into cpu_ack.

Parameters:
- BASE, 16'o176560: base address, 8-byte aligned; bits [2:0] ignored.
- DIV, 217: clk_sys cycles per bit (must be ≥ 8).

Ports:
- clk_sys  in  1: system clock.
- reset_n  in  1: asynchronous, active-low reset.
- ce  in  1: bus clock enable (ce_bus).
- init  in  1: bus INIT, synchronous reset of registers, same effect as reset_n.
- bus_addr  in  16: CPU address.
- bus_sync  in  1: address valid.
- bus_we  in  1: 1 = write cycle.
- bus_wtbt  in  2: byte enables; [0] low byte, [1] high byte.
- bus_stb  in  1: din or dout strobe.
- bus_din  in  16: write data from CPU.
- bus_dout  out  16: read data; 0 when not selected.
- bus_ack  out  1: reply (RPLY).
- rxd  in  1: serial input, asynchronous to clk_sys.
- txd  out  1: serial output, idle 1.
- rx_req  out  1: receive interrupt request.
- rx_ack  in  1: vic acknowledge for rx_req.
- tx_req  out  1: transmit interrupt request.
- tx_ack  in  1: vic acknowledge for tx_req.

Behaviour:
- **Reset values** (reset_n low or init high):
  - Outputs: bus_dout=0, bus_ack=0, txd=1, rx_req=0, tx_req=0.
  - Registers: RX_DONE=0, RX_IE=0, TX_IE=0, MAINT=0, TX_READY=1, error bits=0.
  - Both shifters go idle.
- **Select:** sel = bus_sync & (bus_addr[15:3] == BASE[15:3]). Register index = bus_addr[2:1].
- **Read data:** bus_dout = register value while sel & bus_stb & !bus_we, else 0. The value is combinational from registers.
- **Ack:** sampled on ce.
  - bus_ack rises at the first ce with sel & bus_stb.
  - It holds while bus_stb is high and drops at the first ce after bus_stb falls.
  - Unselected addresses never ack.
- **Write/read side effects** fire once per cycle, on the clk_sys rising edge where sel & bus_stb goes 0→1 (edge-detected, not per ce).
  - Writes honour bus_wtbt. Writes to read-only bits are ignored.
- **RCSR** (+0):
  - bit15 RX_ERR (RO) = OR of RBUF[14:13].
  - bit7 RX_DONE (RO).
  - bit6 RX_IE (RW, low byte).
  - Other bits read 0.
- **RBUF** (+2, RO):
  - [7:0] data, bit15 = bit14|bit13, bit14 overrun, bit13 framing.
  - A read clears RX_DONE. Data and error bits persist until the next frame.
- **XCSR** (+4):
  - bit7 TX_READY (RO), bit6 TX_IE (RW), bit2 MAINT (RW).
  - MAINT=1 loops the transmitter into the receiver and forces txd=1.
- **XBUF** (+6, WO, reads 0):
  - Low-byte write while TX_READY=1 latches the byte, clears TX_READY and starts the frame next cycle.
  - A write while TX_READY=0 is ignored.
  - A high-byte-only write is ignored.
- **TX FSM** (IDLE→START→DATA[0..7] LSB first→STOP→IDLE):
  - Each state lasts DIV cycles.
  - TX_READY sets on entry to STOP, which lets back-to-back writes overlap the stop bit.
- **RX FSM** (IDLE→START→DATA→STOP):
  - Source: rxd (2-flop synchronised), or the tx line when MAINT=1.
  - Falling edge in IDLE → wait DIV/2 cycles → sample. If high, it is a glitch: back to IDLE with no side effects. Otherwise sample every DIV cycles.
  - At the stop sample, latch data into RBUF and set RX_DONE:
    - framing bit = stop sample was 0.
    - overrun bit = RX_DONE was already 1 at latch time.
  - Return to IDLE immediately after the stop sample.
- **Simultaneous events:** if the RBUF read edge and the RX latch coincide, the latch wins: RX_DONE=1, new data.
- **Interrupts:** per channel, cond = IE & flag (RX_DONE or TX_READY).
  - Pending sets on the 0→1 transition of cond, including IE being written to 1 while the flag is already 1.
  - Pending clears on the matching ack or when cond falls.
  - req = pending.
- **Mid-operation:** reset or init during a frame aborts it immediately (txd=1), with no partial latch.

Decomposition:
- Package dl11_pkg:
  - Register index constants: RCSR=0, RBUF=1, XCSR=2, XBUF=3.
  - Bit position constants: DONE/READY=7, IE=6, MAINT=2, ERR=15, OVR=14, FRM=13.
  - Enum typedef for TX/RX states.
- One sub-module, dl11_rx_shifter: synchroniser, RX FSM and bit counter. Outputs a data byte, a framing flag and a 1-cycle valid pulse.
- The TX shifter, bus decode and interrupt logic stay in the top module.

Test Plan:
1. Reset, then read 176564 → 16'o000200 (TX_READY); read 176560 → 0; txd=1; every read acks and bus_ack drops after bus_stb falls.
2. DIV=16: write 16'o000125 to 176566 → txd shows start 0, bits 1,0,1,0,1,0,1,0, stop 1, each 16 cycles; XCSR bit7 is 0 during the frame and sets at the stop bit.
3. Drive rxd frame 0xA5 → RCSR=16'o000200, RBUF=16'o000245; RBUF read → RCSR=0.
4. Two frames with no RBUF read → RBUF=16'o140xxx with second-frame data; frame with stop=0 → RBUF bit13 and bit15 set.
5. Write RCSR=16'o000100 with RX_DONE=1 → rx_req rises; pulse rx_ack → rx_req=0 and does not re-raise until RX_DONE cycles 0→1.
6. MAINT=1, write 0x3C to XBUF → txd stays 1, RBUF=16'o000074 after one frame; assert reset_n low mid-frame → all outputs return to reset values.
